// File: rtl/pe_receive_monitor_if.sv
// Ejection-port bundle for pe_receive_monitor: router flit write port plus the record drain handshake.
interface pe_receive_monitor_if #(
    parameter int flit_width = 264
);
    logic                  w_valid_pe;
    logic [flit_width-1:0] w_data_pe;
    logic                  rec_valid;
    logic                  rec_ready;
    logic [15:0]           rec_src;
    logic [31:0]           rec_inject;
    logic [31:0]           rec_latency;

    modport master (
        output w_valid_pe, w_data_pe, rec_ready,
        input  rec_valid, rec_src, rec_inject, rec_latency
    );

    modport slave (
        input  w_valid_pe, w_data_pe, rec_ready,
        output rec_valid, rec_src, rec_inject, rec_latency
    );
endinterface

// File: rtl/pe_receive_monitor.sv
// pe_receive_monitor: per-PE NoC ejection sink with latency statistics and a FWFT record FIFO.
// Define SEQ_CHECK_EN to enable per-source sequence-number checking.
module pe_receive_monitor #(
    parameter int X          = 10,
    parameter int Y          = 10,
    parameter int x_size     = $clog2(X),
    parameter int y_size     = $clog2(Y),
    parameter int data_width = 256,
    parameter int MY_X       = 0,
    parameter int MY_Y       = 0,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                clk,
    input  logic                rstn,
    pe_receive_monitor_if.slave ej,
    input  logic [31:0]         cur_time,
    output logic [31:0]         receive_count,
    output logic [15:0]         err_count,
    output logic [31:0]         lat_min,
    output logic [31:0]         lat_max,
    output logic [47:0]         lat_sum,
    output logic                rec_overflow
);
    localparam int XY    = x_size + y_size;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int REC_W = 80;

    logic              s1_valid;
    logic [x_size-1:0] s1_dx;
    logic [y_size-1:0] s1_dy;
    logic [31:0]       s1_inject;
    logic [31:0]       s1_time;
    logic [15:0]       s1_src;

    logic [31:0] latency;
    logic        addr_ok;
    logic        seq_err;
    logic        push;
    logic        pop;
    logic        push_ok;
    logic        full;
    logic        empty;

    logic [REC_W-1:0] mem [FIFO_DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    // Payload bits above the monitor fields are carried by the flit but never inspected.
    logic unused_flit_bits;
    assign unused_flit_bits = ^ej.w_data_pe[XY+data_width-1:XY+48];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= ej.w_valid_pe;
        end
        if (ej.w_valid_pe) begin
            s1_dx     <= ej.w_data_pe[x_size-1:0];
            s1_dy     <= ej.w_data_pe[XY-1:x_size];
            s1_inject <= ej.w_data_pe[XY+31:XY];
            s1_src    <= ej.w_data_pe[XY+47:XY+32];
            s1_time   <= cur_time;
        end
    end

    assign latency = s1_time - s1_inject;
    assign addr_ok = (s1_dx == x_size'(MY_X)) && (s1_dy == y_size'(MY_Y));

`ifdef SEQ_CHECK_EN
    localparam int NPE = X * Y;
    localparam int IW  = (NPE > 1) ? $clog2(NPE) : 1;

    logic [31:0]   s1_seq;
    logic [31:0]   exp_seq [NPE];
    logic          src_in_range;
    logic [IW-1:0] src_idx;

    always_ff @(posedge clk) begin
        if (ej.w_valid_pe) begin
            s1_seq <= ej.w_data_pe[XY+79:XY+48];
        end
    end

    assign src_in_range = s1_src < 16'(NPE);
    assign src_idx      = s1_src[IW-1:0];
    assign seq_err      = addr_ok && src_in_range && (s1_seq != exp_seq[src_idx]);

    // A mismatch resynchronises the expectation so one lost packet costs one error.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < NPE; i++) begin
                exp_seq[i] <= 32'd0;
            end
        end else if (s1_valid && addr_ok && src_in_range) begin
            exp_seq[src_idx] <= s1_seq + 32'd1;
        end
    end
`else
    assign seq_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rstn) begin
            receive_count <= 32'd0;
            err_count     <= 16'd0;
            lat_min       <= 32'hFFFF_FFFF;
            lat_max       <= 32'd0;
            lat_sum       <= 48'd0;
        end else if (s1_valid) begin
            receive_count <= receive_count + 32'd1;
            if ((!addr_ok || seq_err) && (err_count != 16'hFFFF)) begin
                err_count <= err_count + 16'd1;
            end
            if (addr_ok) begin
                if (latency < lat_min) begin
                    lat_min <= latency;
                end
                if (latency > lat_max) begin
                    lat_max <= latency;
                end
                lat_sum <= lat_sum + {16'd0, latency};
            end
        end
    end

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push    = s1_valid && addr_ok;
    assign pop     = !empty && ej.rec_ready;
    // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
    assign push_ok = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= {s1_src, s1_inject, latency};
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            rec_overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
            if (push && !push_ok) begin
                rec_overflow <= 1'b1;
            end
        end
    end

    assign ej.rec_valid = !empty;
    assign {ej.rec_src, ej.rec_inject, ej.rec_latency} = mem[rd_ptr[AW-1:0]];
endmodule

// File: tb/tb_pe_receive_monitor.sv
// Directed self-checking bench for pe_receive_monitor (PE at column 2, row 3, 4-entry record FIFO).
module tb_pe_receive_monitor;
    localparam int X  = 10;
    localparam int Y  = 10;
    localparam int DW = 256;
    localparam int FW = 4 + 4 + DW;
    localparam int DEPTH = 4;
`ifdef SEQ_CHECK_EN
    localparam int SEQ_ERRS = 1;
`else
    localparam int SEQ_ERRS = 0;
`endif

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] cur_time;
    logic [31:0] receive_count;
    logic [15:0] err_count;
    logic [31:0] lat_min;
    logic [31:0] lat_max;
    logic [47:0] lat_sum;
    logic        rec_overflow;

    int checks   = 0;
    int failures = 0;

    pe_receive_monitor_if #(.flit_width(FW)) bus ();

    pe_receive_monitor #(
        .X(X), .Y(Y), .data_width(DW), .MY_X(2), .MY_Y(3), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .ej(bus.slave),
        .cur_time(cur_time),
        .receive_count(receive_count),
        .err_count(err_count),
        .lat_min(lat_min),
        .lat_max(lat_max),
        .lat_sum(lat_sum),
        .rec_overflow(rec_overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [FW-1:0] make_flit(input logic [3:0] dx, input logic [3:0] dy,
                                                input logic [31:0] inj, input logic [15:0] src,
                                                input logic [31:0] seq);
        logic [FW-1:0] f;
        f = '1;
        f[3:0]   = dx;
        f[7:4]   = dy;
        f[39:8]  = inj;
        f[55:40] = src;
        f[87:56] = seq;
        return f;
    endfunction

    task automatic stepCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Presents one flit for exactly one capture edge; returns 1 time unit after that edge.
    task automatic applyStimulus(input logic [3:0] dx, input logic [3:0] dy, input logic [31:0] inj,
                                 input logic [15:0] src, input logic [31:0] seq, input logic [31:0] t);
        bus.w_valid_pe = 1'b1;
        bus.w_data_pe  = make_flit(dx, dy, inj, src, seq);
        cur_time       = t;
        @(posedge clk);
        #1;
        bus.w_valid_pe = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        logic [15:0] exp_src [4];
        logic [31:0] exp_lat [4];
        logic [31:0] exp_inj [4];
        exp_src = '{16'd21, 16'd22, 16'd23, 16'd30};
        exp_lat = '{32'd41, 32'd42, 32'd43, 32'd50};
        exp_inj = '{32'd2010, 32'd2020, 32'd2030, 32'd3000};

        rstn           = 1'b0;
        cur_time       = 32'd0;
        bus.w_valid_pe = 1'b0;
        bus.w_data_pe  = '0;
        bus.rec_ready  = 1'b0;
        stepCycles(3);
        checkOutput("rst_receive_count", 64'(receive_count), 64'd0);
        checkOutput("rst_err_count", 64'(err_count), 64'd0);
        checkOutput("rst_lat_min", 64'(lat_min), 64'hFFFF_FFFF);
        checkOutput("rst_lat_max", 64'(lat_max), 64'd0);
        checkOutput("rst_lat_sum", 64'(lat_sum), 64'd0);
        checkOutput("rst_rec_valid", 64'(bus.rec_valid), 64'd0);
        checkOutput("rst_rec_overflow", 64'(rec_overflow), 64'd0);
        rstn = 1'b1;
        stepCycles(1);

        $display("[TB] single addressed flit");
        applyStimulus(4'd2, 4'd3, 32'd100, 16'd5, 32'd0, 32'd130);
        checkOutput("pipe_not_yet_counted", 64'(receive_count), 64'd0);
        checkOutput("pipe_not_yet_valid", 64'(bus.rec_valid), 64'd0);
        stepCycles(1);
        checkOutput("one_receive_count", 64'(receive_count), 64'd1);
        checkOutput("one_lat_min", 64'(lat_min), 64'd30);
        checkOutput("one_lat_max", 64'(lat_max), 64'd30);
        checkOutput("one_lat_sum", 64'(lat_sum), 64'd30);
        checkOutput("one_rec_valid", 64'(bus.rec_valid), 64'd1);
        checkOutput("one_rec_src", 64'(bus.rec_src), 64'd5);
        checkOutput("one_rec_inject", 64'(bus.rec_inject), 64'd100);
        checkOutput("one_rec_latency", 64'(bus.rec_latency), 64'd30);
        bus.rec_ready = 1'b1;
        stepCycles(1);
        bus.rec_ready = 1'b0;
        checkOutput("one_popped", 64'(bus.rec_valid), 64'd0);

        $display("[TB] misaddressed flit");
        applyStimulus(4'd1, 4'd3, 32'd200, 16'd6, 32'd0, 32'd300);
        stepCycles(1);
        checkOutput("miss_receive_count", 64'(receive_count), 64'd2);
        checkOutput("miss_err_count", 64'(err_count), 64'd1);
        checkOutput("miss_no_record", 64'(bus.rec_valid), 64'd0);
        checkOutput("miss_lat_sum", 64'(lat_sum), 64'd30);
        checkOutput("miss_lat_max", 64'(lat_max), 64'd30);

        $display("[TB] timestamp wrap and new minimum");
        applyStimulus(4'd2, 4'd3, 32'hFFFF_FFF0, 16'd7, 32'd0, 32'h10);
        stepCycles(1);
        checkOutput("wrap_rec_latency", 64'(bus.rec_latency), 64'h20);
        checkOutput("wrap_rec_src", 64'(bus.rec_src), 64'd7);
        checkOutput("wrap_lat_max", 64'(lat_max), 64'd32);
        checkOutput("wrap_lat_min", 64'(lat_min), 64'd30);
        bus.rec_ready = 1'b1;
        applyStimulus(4'd2, 4'd3, 32'd1000, 16'd9, 32'd0, 32'd1010);
        stepCycles(1);
        bus.rec_ready = 1'b0;
        checkOutput("min_rec_latency", 64'(bus.rec_latency), 64'd10);
        checkOutput("min_lat_min", 64'(lat_min), 64'd10);
        checkOutput("min_lat_sum", 64'(lat_sum), 64'd72);
        bus.rec_ready = 1'b1;
        stepCycles(1);
        bus.rec_ready = 1'b0;
        checkOutput("min_drained", 64'(bus.rec_valid), 64'd0);

        $display("[TB] overflow with back-to-back flits");
        for (int i = 0; i <= DEPTH; i++) begin
            applyStimulus(4'd2, 4'd3, 32'(2000 + 10 * i), 16'(20 + i), 32'd0, 32'(2040 + 11 * i));
        end
        stepCycles(1);
        checkOutput("ovf_receive_count", 64'(receive_count), 64'd9);
        checkOutput("ovf_flag", 64'(rec_overflow), 64'd1);
        checkOutput("ovf_lat_max", 64'(lat_max), 64'd44);
        checkOutput("ovf_lat_sum", 64'(lat_sum), 64'd282);
        checkOutput("ovf_err_count", 64'(err_count), 64'd1);
        checkOutput("ovf_head_src", 64'(bus.rec_src), 64'd20);
        stepCycles(1);
        checkOutput("hold_src", 64'(bus.rec_src), 64'd20);
        checkOutput("hold_latency", 64'(bus.rec_latency), 64'd40);

        $display("[TB] push and pop on a full FIFO");
        applyStimulus(4'd2, 4'd3, 32'd3000, 16'd30, 32'd0, 32'd3050);
        bus.rec_ready = 1'b1;
        stepCycles(1);
        bus.rec_ready = 1'b0;
        checkOutput("full_receive_count", 64'(receive_count), 64'd10);
        checkOutput("full_lat_max", 64'(lat_max), 64'd50);
        checkOutput("full_lat_sum", 64'(lat_sum), 64'd332);
        checkOutput("full_ovf_sticky", 64'(rec_overflow), 64'd1);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("drain%0d_valid", i), 64'(bus.rec_valid), 64'd1);
            checkOutput($sformatf("drain%0d_src", i), 64'(bus.rec_src), 64'(exp_src[i]));
            checkOutput($sformatf("drain%0d_inject", i), 64'(bus.rec_inject), 64'(exp_inj[i]));
            checkOutput($sformatf("drain%0d_latency", i), 64'(bus.rec_latency), 64'(exp_lat[i]));
            bus.rec_ready = 1'b1;
            stepCycles(1);
            bus.rec_ready = 1'b0;
        end
        checkOutput("drain_empty", 64'(bus.rec_valid), 64'd0);

        $display("[TB] sequence numbers 0,1,3,4 from source 3");
        bus.rec_ready = 1'b1;
        applyStimulus(4'd2, 4'd3, 32'd4000, 16'd3, 32'd0, 32'd4001);
        applyStimulus(4'd2, 4'd3, 32'd4010, 16'd3, 32'd1, 32'd4011);
        applyStimulus(4'd2, 4'd3, 32'd4020, 16'd3, 32'd3, 32'd4021);
        stepCycles(1);
        checkOutput("seq_gap_err_count", 64'(err_count), 64'(1 + SEQ_ERRS));
        checkOutput("seq_gap_receive_count", 64'(receive_count), 64'd13);
        applyStimulus(4'd2, 4'd3, 32'd4030, 16'd3, 32'd4, 32'd4031);
        stepCycles(1);
        bus.rec_ready = 1'b0;
        checkOutput("seq_resync_err_count", 64'(err_count), 64'(1 + SEQ_ERRS));
        checkOutput("seq_receive_count", 64'(receive_count), 64'd14);
        checkOutput("seq_lat_min", 64'(lat_min), 64'd1);
        checkOutput("seq_lat_sum", 64'(lat_sum), 64'd336);

        $display("[TB] reset with a flit in flight");
        applyStimulus(4'd2, 4'd3, 32'd5000, 16'd8, 32'd0, 32'd5005);
        rstn = 1'b0;
        stepCycles(1);
        checkOutput("midrst_receive_count", 64'(receive_count), 64'd0);
        checkOutput("midrst_err_count", 64'(err_count), 64'd0);
        checkOutput("midrst_lat_min", 64'(lat_min), 64'hFFFF_FFFF);
        checkOutput("midrst_overflow", 64'(rec_overflow), 64'd0);
        checkOutput("midrst_rec_valid", 64'(bus.rec_valid), 64'd0);
        rstn = 1'b1;
        stepCycles(2);
        checkOutput("postrst_receive_count", 64'(receive_count), 64'd0);
        checkOutput("postrst_rec_valid", 64'(bus.rec_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pe_receive_monitor.md
# pe_receive_monitor

Per-PE traffic sink and latency monitor on the NoC ejection port. It accepts every flit the router delivers on its write port (no backpressure exists on that path) and checks that the destination matches this PE. It extracts the source ID, sequence number and injection timestamp, computes latency against the shared cycle counter, and keeps counters. Each received packet produces a latency record, buffered in a small FIFO, for a log/CSV drain. One instance sits beside each PE traffic generator in the mesh bench wrapper.

## Interface
- X, 10, mesh columns
- Y, 10, mesh rows
- x_size, $clog2(X), dest-x field width
- y_size, $clog2(Y), dest-y field width
- data_width, 256, payload width; must be ≥ 80
- MY_X, 0, this PE's column
- MY_Y, 0, this PE's row
- FIFO_DEPTH, 8, record FIFO entries; power of 2, ≥ 2

- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- w_valid_pe  in  1  flit valid from router; single-cycle, no ready
- w_data_pe  in  x_size+y_size+data_width  flit
- cur_time  in  32  global free-running cycle counter
- receive_count  out  32  packets accepted
- err_count  out  16  address/sequence errors
- lat_min  out  32  minimum latency seen
- lat_max  out  32  maximum latency seen
- lat_sum  out  48  sum of latencies
- rec_valid  out  1  record available
- rec_ready  in  1  record consumed
- rec_src  out  16  source PE index
- rec_inject  out  32  inject timestamp
- rec_latency  out  32  latency in cycles
- rec_overflow  out  1  sticky: a record was dropped

## Operation
- Flit layout:
  - [x_size-1:0] dest x; [x_size+y_size-1:x_size] dest y; data field D above.
  - D[31:0] inject time; D[47:32] source index (y*X+x); D[79:48] sequence number.
- Stage 1: on w_valid_pe, register flit and cur_time.
- Stage 2:
  - latency = captured_time − inject, modulo 2^32 (wrap-safe).
  - addr_ok = (dest x == MY_X) && (dest y == MY_Y).
- Stage 2 updates:
  - receive_count +1 for every flit, even if misaddressed.
  - err_count +1 if !addr_ok; saturates at 16'hFFFF.
  - lat_min/lat_max/lat_sum updated only when addr_ok. lat_sum wraps. First valid packet loads both min and max.
- Record push: a record is pushed only when addr_ok.
  - FIFO full on push: record dropped; rec_overflow set until reset. Counters still update.
- FIFO: first-word-fall-through. rec_valid = !empty. Pop on rec_valid && rec_ready. Push and pop in the same cycle while full: the push succeeds (pop frees the slot).
- No state machine beyond the 2-stage pipe. Back-to-back flits every cycle are sustained.

## Timing
- Reset outputs:
  - receive_count, err_count, lat_sum, lat_max = 0; lat_min = 32'hFFFFFFFF.
  - rec_valid = 0, rec_overflow = 0. FIFO emptied; pipe valids cleared.
- Flit at edge N: counters visible after edge N+2. rec_valid is high after edge N+2 if the FIFO was empty.
- rec_* held stable while rec_valid && !rec_ready.
- Reset asserted mid-pipeline discards in-flight flits; no count increments.
- Address or sequence error on one flit increments err_count once (max 1 per flit).

## Configuration
- SEQ_CHECK_EN defined:
  - Per-source register array of X*Y expected sequence numbers, reset to 0.
  - An addr_ok flit whose seq differs from its source's expected value increments err_count.
  - Expected value is then set to seq+1 (resync).
- SEQ_CHECK_EN undefined: sequence field ignored; no array instantiated.

## Test plan
- Reset, one flit dest (MY_X,MY_Y), inject=100, src=5, arriving with cur_time=130 → receive_count=1, lat_min=lat_max=lat_sum=30, record {5,100,30} valid 2 cycles later.
- Flit with dest x≠MY_X → receive_count=1, err_count=1, no record, latency stats unchanged.
- inject=32'hFFFFFFF0, cur_time=0x10 → latency=0x20 (wrap).
- rec_ready=0, FIFO_DEPTH+1 valid flits back-to-back → FIFO full, one record dropped, rec_overflow=1, receive_count=FIFO_DEPTH+1.
- Full FIFO, rec_ready=1 with a new flit → no drop, occupancy stays FIFO_DEPTH, records drain in order.
- SEQ_CHECK_EN: src 3 sends seq 0, 1, 3, 4 → err_count=1 (at seq 3), seq 4 accepted without error.
